// File: rtl/gray_ptr_tx_pkg.sv
// Shared async-FIFO helpers: pointer width, default almost-full threshold
// and the binary-to-Gray encoder used by the pointer crossing.
package gray_ptr_tx_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned afull_thresh_default(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd2;
  endfunction

  // Pointers up to 32 bits are encoded; callers zero-extend and truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr_tx_gray_to_bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared with the read-side pointer logic.
module gray_to_bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_ptr_tx.sv
// Write-side pointer and full-flag generator for the async FIFO.
// Define GRAY_PTR_TX_AFULL_EN to build fill_level_o / almost_full_o.
module gray_ptr_tx
  import gray_ptr_tx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH = afull_thresh_default(ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_gray_synced_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_ack_o,
  output logic [ADDR_WIDTH:0]   wr_gray_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   fill_level_o
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);
  // Full when the write Gray pointer equals the read pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  if (ADDR_WIDTH < 2) begin : g_bad_width
    $error("gray_ptr_tx: ADDR_WIDTH must be at least 2");
  end
  if (AFULL_THRESH > (32'd1 << ADDR_WIDTH)) begin : g_bad_thresh
    $error("gray_ptr_tx: AFULL_THRESH exceeds FIFO depth");
  end

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic          full_next;

  assign wr_ack_o     = wr_en_i && !full_o;
  assign wr_addr_o    = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_next  = wr_bin + PW'(wr_ack_o);
  assign wr_gray_next = PW'(bin2gray(32'(wr_bin_next)));
  assign full_next    = (wr_gray_next == (rd_gray_synced_i ^ FULL_MASK));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_bin     <= '0;
      wr_gray_o  <= '0;
      full_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      wr_bin     <= wr_bin_next;
      wr_gray_o  <= wr_gray_next;
      full_o     <= full_next;
      overflow_o <= wr_en_i && full_o;
    end
  end

`ifdef GRAY_PTR_TX_AFULL_EN
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] fill_next;

  gray_to_bin #(
    .WIDTH (PW)
  ) u_rd_g2b (
    .gray_i (rd_gray_synced_i),
    .bin_o  (rd_bin)
  );

  assign fill_next = wr_bin_next - rd_bin;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_level_o  <= '0;
      almost_full_o <= 1'b0;
    end else begin
      fill_level_o  <= fill_next;
      almost_full_o <= (fill_next >= AFULL_T);
    end
  end
`else
  assign fill_level_o  = '0;
  assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_tx.sv
// Directed self-checking bench for gray_ptr_tx at ADDR_WIDTH=2, AFULL_THRESH=3.
module tb_gray_ptr_tx;

`ifdef GRAY_PTR_TX_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] rd_gray = '0;
  logic [1:0] wr_addr;
  logic       wr_ack;
  logic [2:0] wr_gray;
  logic       full;
  logic       overflow;
  logic       almost_full;
  logic [2:0] fill_level;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  gray_ptr_tx #(
    .ADDR_WIDTH   (2),
    .AFULL_THRESH (3)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .wr_en_i          (wr_en),
    .rd_gray_synced_i (rd_gray),
    .wr_addr_o        (wr_addr),
    .wr_ack_o         (wr_ack),
    .wr_gray_o        (wr_gray),
    .full_o           (full),
    .overflow_o       (overflow),
    .almost_full_o    (almost_full),
    .fill_level_o     (fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_fill(input string tag, input int unsigned lvl, input bit af);
    check({tag, "_fill"}, 32'(fill_level), AF_EN ? lvl : 0);
    check({tag, "_afull"}, 32'(almost_full), AF_EN ? 32'(af) : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] g3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [2:0] gray_seq [4] = '{3'd1, 3'd3, 3'd2, 3'd6};
  logic [2:0] prev_gray;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_gray", 32'(wr_gray), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check_fill("rst", 0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Fill the FIFO with the read pointer at 0
    wr_en = 1'b1;
    #1 check("ack_empty", 32'(wr_ack), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fill_gray", 32'(wr_gray), 32'(gray_seq[i]));
      check("fill_addr", 32'(wr_addr), 32'((i + 1) % 4));
      check("fill_full", 32'(full), (i == 3) ? 1 : 0);
      check_fill("fill", i + 1, i >= 2);
    end

    // Writes against a full FIFO are rejected
    check("ack_full", 32'(wr_ack), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ovf_gray", 32'(wr_gray), 6);
      check("ovf_pulse", 32'(overflow), 1);
      check("ovf_full", 32'(full), 1);
    end
    wr_en = 1'b0;
    tick();
    check("ovf_end", 32'(overflow), 0);

    // Read pointer advance releases full; one more write refills
    rd_gray = 3'd1;
    tick();
    check("rel_full", 32'(full), 0);
    check_fill("rel", 3, 1'b1);
    wr_en = 1'b1;
    tick();
    check("refill_gray", 32'(wr_gray), 7);
    check("refill_full", 32'(full), 1);
    check_fill("refill", 4, 1'b1);
    wr_en = 1'b0;

    // Continuous write with read keeping up
    do_reset();
    rd_gray = '0;
    wr_en = 1'b1;
    prev_gray = wr_gray;
    for (int k = 0; k < 20; k++) begin
      rd_gray = g3(3'(k));
      tick();
      check("cont_gray", 32'(wr_gray), 32'(g3(3'(k + 1))));
      check("cont_hamm", $countones(prev_gray ^ wr_gray), 1);
      if ((k + 1) % 8 == 0) check("cont_wrap", 32'(wr_gray), 0);
      check("cont_full", 32'(full), 0);
      prev_gray = wr_gray;
    end
    wr_en = 1'b0;

    // Almost-full threshold
    do_reset();
    rd_gray = '0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fill("af", i + 1, i == 2);
    end
    wr_en = 1'b0;
    rd_gray = 3'd1;
    tick();
    check_fill("af_drop", 2, 1'b0);

    // Asynchronous reset mid-burst
    do_reset();
    rd_gray = 3'd3;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_gray", 32'(wr_gray), 7);
    check("mid_full", 32'(full), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gray", 32'(wr_gray), 0);
    check("arst_addr", 32'(wr_addr), 0);
    check("arst_full", 32'(full), 0);
    check("arst_ovf", 32'(overflow), 0);
    check_fill("arst", 0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_gray", 32'(wr_gray), 1);
    check("post_addr", 32'(wr_addr), 1);
    wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
